// File: rtl/pd_pkg.sv
// Shared types and defaults for the pulse_stats measurement slice.
// Pulse_stats and pstat_fifo both import it.
package pd_pkg;

   localparam int PSTAT_CNT_W      = 16;
   localparam int PSTAT_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } pstat_state_e;

   typedef struct packed {
      logic [PSTAT_CNT_W-1:0] period;
      logic [PSTAT_CNT_W-1:0] width;
   } pstat_rec_t;

endpackage

// File: rtl/pulse_stats_if.sv
// Measurement record stream: valid/ready handshake carrying {period, width}.
// The record source drives through the master modport; the consumer uses slave.
interface pulse_stats_if
   import pd_pkg::*;
#(
   parameter int CNT_W = PSTAT_CNT_W
);
   logic             meas_valid;
   logic             meas_ready;
   logic [CNT_W-1:0] meas_period;
   logic [CNT_W-1:0] meas_width;

   modport master (
      output meas_valid,
      output meas_period,
      output meas_width,
      input  meas_ready
   );

   modport slave (
      input  meas_valid,
      input  meas_period,
      input  meas_width,
      output meas_ready
   );
endinterface

// File: rtl/pstat_fifo.sv
// Record FIFO, write visible one cycle after push; no fall-through when empty.
// When full, a push is accepted only alongside a pop; head holds the last popped entry when empty.
module pstat_fifo
   import pd_pkg::*;
#(
   parameter type T     = pstat_rec_t,
   parameter int  DEPTH = PSTAT_FIFO_DEPTH
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  T     push_dat,
   input  logic pop,
   output T     head_dat,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   T               mem [DEPTH];
   logic [AW:0]    wr_ptr_q;
   logic [AW:0]    rd_ptr_q;
   logic [AW-1:0]  wr_idx;
   logic [AW-1:0]  rd_idx;
   logic [AW-1:0]  last_idx;
   logic           wr_en;
   logic           rd_en;

   assign wr_idx   = wr_ptr_q[AW-1:0];
   assign rd_idx   = rd_ptr_q[AW-1:0];
   assign last_idx = rd_idx - AW'(1);

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;

   // Slot behind the read pointer is the entry popped last, so the outputs hold it.
   assign head_dat = empty ? mem[last_idx] : mem[rd_idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_idx] <= push_dat;
            wr_ptr_q    <= wr_ptr_q + (AW+1)'(1);
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/pulse_stats.sv
// Measures period/width of each pulse, queues {period,width} records; PSTAT_TIMEOUT_EN adds an idle timeout.
// Record written at the closing rise, meas_valid next cycle; a push into a full FIFO without pop is dropped and sets overflow.
module pulse_stats
   import pd_pkg::*;
#(
   parameter int CNT_W      = PSTAT_CNT_W,
`ifdef PSTAT_TIMEOUT_EN
   parameter int TIMEOUT    = 1024,
`endif
   parameter int FIFO_DEPTH = PSTAT_FIFO_DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          pulse_in,
   input  logic          clear_ovf,
   pulse_stats_if.master meas,
`ifdef PSTAT_TIMEOUT_EN
   output logic          timeout,
`endif
   output logic          overflow
);

   typedef struct packed {
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] width;
   } rec_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   pstat_state_e     state_q;
   pstat_state_e     state_d;
   logic             prev_q;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] per_cnt_q;
   logic [CNT_W-1:0] per_cnt_d;
   logic [CNT_W-1:0] wid_cnt_q;
   logic [CNT_W-1:0] wid_cnt_d;
   logic [CNT_W-1:0] wid_lat_q;
   logic [CNT_W-1:0] wid_lat_d;
   logic             push;
   logic             pop;
   logic             drop;
   logic             full;
   logic             empty;
   rec_t             push_rec;
   rec_t             head_rec;
`ifdef PSTAT_TIMEOUT_EN
   logic             tmo_d;
`endif

   assign rise = pulse_in & ~prev_q;
   assign fall = ~pulse_in & prev_q;

   always_comb begin
      state_d   = state_q;
      per_cnt_d = per_cnt_q;
      wid_cnt_d = wid_cnt_q;
      wid_lat_d = wid_lat_q;
      push      = 1'b0;
`ifdef PSTAT_TIMEOUT_EN
      tmo_d     = 1'b0;
`endif
      if (!enable) begin
         state_d   = IDLE;
         per_cnt_d = '0;
         wid_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: state_d = ARM;
            ARM: begin
               if (rise) begin
                  per_cnt_d = CNT_ONE;
                  wid_cnt_d = CNT_ONE;
                  state_d   = HIGH;
               end
            end
            HIGH: begin
               // The fall cycle still counts towards the period but not the width.
               per_cnt_d = sat_inc(per_cnt_q);
               if (fall) begin
                  wid_lat_d = wid_cnt_q;
                  state_d   = LOW;
               end else begin
                  wid_cnt_d = sat_inc(wid_cnt_q);
               end
            end
            LOW: begin
               if (rise) begin
                  push      = 1'b1;
                  per_cnt_d = CNT_ONE;
                  wid_cnt_d = CNT_ONE;
                  state_d   = HIGH;
               end else begin
                  per_cnt_d = sat_inc(per_cnt_q);
               end
            end
            default: state_d = IDLE;
         endcase
`ifdef PSTAT_TIMEOUT_EN
         if ((state_q == HIGH || state_q == LOW) && !rise &&
             (per_cnt_q >= CNT_W'(TIMEOUT))) begin
            tmo_d     = 1'b1;
            push      = 1'b0;
            per_cnt_d = '0;
            wid_cnt_d = '0;
            state_d   = ARM;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         prev_q    <= 1'b0;
         per_cnt_q <= '0;
         wid_cnt_q <= '0;
         wid_lat_q <= '0;
         overflow  <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= pulse_in;
         per_cnt_q <= per_cnt_d;
         wid_cnt_q <= wid_cnt_d;
         wid_lat_q <= wid_lat_d;
         if (drop) begin
            overflow <= 1'b1;
         end else if (clear_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

`ifdef PSTAT_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeout <= 1'b0;
      end else begin
         timeout <= tmo_d;
      end
   end
`endif

   assign push_rec = {per_cnt_q, wid_lat_q};
   assign pop      = meas.meas_valid & meas.meas_ready;
   assign drop     = push & full & ~pop;

   pstat_fifo #(
      .T     (rec_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat (push_rec),
      .pop      (pop),
      .head_dat (head_rec),
      .full     (full),
      .empty    (empty)
   );

   assign meas.meas_valid  = ~empty;
   assign meas.meas_period = head_rec.period;
   assign meas.meas_width  = head_rec.width;

endmodule

// File: tb/tb_pulse_stats.sv
// Randomised bench for pulse_stats; expected records derive from the pulse shapes driven
// (period = high+low cycles, width = high cycles, saturated), compared with what the consumer sees.
`timescale 1ns/1ps
module tb_pulse_stats;
   import pd_pkg::*;

   localparam int CNT_W = 16;
   localparam int SMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   logic pulse_in;
   logic clear_ovf;
   logic overflow;
`ifdef PSTAT_TIMEOUT_EN
   logic timeout;
`endif

   pulse_stats_if #(.CNT_W(CNT_W)) meas ();

   pulse_stats #(
      .CNT_W      (CNT_W),
`ifdef PSTAT_TIMEOUT_EN
      .TIMEOUT    (50),
`endif
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .pulse_in  (pulse_in),
      .clear_ovf (clear_ovf),
      .meas      (meas),
`ifdef PSTAT_TIMEOUT_EN
      .timeout   (timeout),
`endif
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   // Consumer-side capture of every accepted record
   logic [31:0] got_p[$];
   logic [31:0] got_w[$];
   always @(negedge clk) begin
      if (reset === 1'b1 && meas.meas_valid === 1'b1 && meas.meas_ready === 1'b1) begin
         got_p.push_back(32'(meas.meas_period));
         got_w.push_back(32'(meas.meas_width));
      end
   end

   logic [31:0] exp_p[$];
   logic [31:0] exp_w[$];

   function automatic logic [31:0] sat(input int v);
      return (v > SMAX) ? 32'(SMAX) : 32'(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_queues();
      got_p.delete(); got_w.delete(); exp_p.delete(); exp_w.delete();
   endtask

   task automatic rearm();
      pulse_in = 1'b0;
      enable   = 1'b0;
      repeat (2) tick();
      enable = 1'b1;
      repeat (2) tick();
   endtask

   task automatic pulse_x(input int h, input int l, input logic clr, input logic rdy);
      pulse_in  = 1'b1;
      clear_ovf = clr;
      if (rdy) meas.meas_ready = 1'b1;
      tick();
      clear_ovf = 1'b0;
      if (rdy) meas.meas_ready = 1'b0;
      repeat (h - 1) tick();
      pulse_in = 1'b0;
      repeat (l) tick();
   endtask

   task automatic pulse(input int h, input int l);
      pulse_x(h, l, 1'b0, 1'b0);
   endtask

   task automatic drain(input int n);
      meas.meas_ready = 1'b1;
      for (int i = 0; i < 300 && got_p.size() < n; i++) tick();
      repeat (3) tick();
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b0; pulse_in = 1'b0; clear_ovf = 1'b0; meas.meas_ready = 1'b0;
      repeat (3) tick();
      n_checks++; if (meas.meas_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", meas.meas_valid); else n_pass++;
      n_checks++; if (meas.meas_period !== 16'd0) $display("FAIL reset_period: got %0d want 0", meas.meas_period); else n_pass++;
      n_checks++; if (meas.meas_width !== 16'd0) $display("FAIL reset_width: got %0d want 0", meas.meas_width); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int rises[$];
      int fv;
      rearm();
      clear_queues();
      meas.meas_ready = 1'b1;
      fv = -1;
      for (int c = 0; c < 30; c++) begin
         pulse_in = (c < 21) && ((c % 7) < 3);
         if (c < 21 && (c % 7) == 0) rises.push_back(cyc + 1);
         tick();
         if (meas.meas_valid === 1'b1 && fv < 0) fv = cyc;
      end
      n_checks++; if (fv != rises[1]) $display("FAIL basic_first_valid: got cycle %0d want %0d", fv, rises[1]); else n_pass++;
      n_checks++; if (got_p.size() != 2) $display("FAIL basic_count: got %0d want 2", got_p.size()); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (i >= got_p.size() || got_p[i] !== 32'd7 || got_w[i] !== 32'd3)
            $display("FAIL basic_rec%0d: got {%0d,%0d} want {7,3}", i,
                     (i < got_p.size()) ? got_p[i] : 0, (i < got_w.size()) ? got_w[i] : 0);
         else n_pass++;
      end
   endtask

   task automatic test_random_stream();
      int n, h, l;
      rearm();
      clear_queues();
      n = 10;
      for (int k = 0; k < n; k++) begin
         h = $urandom_range(2, 8);
         l = $urandom_range(2, 8);
         if (k < n - 1) begin
            exp_p.push_back(sat(h + l));
            exp_w.push_back(sat(h));
         end
         for (int i = 0; i < h + l; i++) begin
            pulse_in = (i < h);
            meas.meas_ready = ((cyc % 2) == 0) || ($urandom_range(0, 1) == 1);
            tick();
         end
      end
      drain(n - 1);
      n_checks++; if (got_p.size() != n - 1) $display("FAIL stream_count: got %0d want %0d", got_p.size(), n - 1); else n_pass++;
      for (int i = 0; i < exp_p.size(); i++) begin
         n_checks++;
         if (i >= got_p.size() || got_p[i] !== exp_p[i] || got_w[i] !== exp_w[i])
            $display("FAIL stream_rec%0d: got {%0d,%0d} want {%0d,%0d}", i,
                     (i < got_p.size()) ? got_p[i] : 0, (i < got_w.size()) ? got_w[i] : 0, exp_p[i], exp_w[i]);
         else n_pass++;
      end
      n_checks++; if (meas.meas_valid !== 1'b0) $display("FAIL stream_empty_valid: got %b want 0", meas.meas_valid); else n_pass++;
      n_checks++;
      if (32'(meas.meas_period) !== exp_p[exp_p.size()-1] || 32'(meas.meas_width) !== exp_w[exp_w.size()-1])
         $display("FAIL stream_hold_last: got {%0d,%0d} want {%0d,%0d}", meas.meas_period, meas.meas_width,
                  exp_p[exp_p.size()-1], exp_w[exp_w.size()-1]);
      else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL stream_overflow: got %b want 0", overflow); else n_pass++;
   endtask

   task automatic test_saturate();
      rearm();
      clear_queues();
      meas.meas_ready = 1'b1;
      pulse((1 << CNT_W) + 5, 10);
      pulse(2, 3);
      drain(1);
      n_checks++; if (got_p.size() != 1) $display("FAIL sat_count: got %0d want 1", got_p.size()); else n_pass++;
      n_checks++;
      if (got_p.size() < 1 || got_p[0] !== 32'(SMAX) || got_w[0] !== 32'(SMAX))
         $display("FAIL sat_rec: got {%0d,%0d} want {%0d,%0d}", (got_p.size() > 0) ? got_p[0] : 0,
                  (got_w.size() > 0) ? got_w[0] : 0, SMAX, SMAX);
      else n_pass++;
   endtask

   task automatic test_overflow();
      rearm();
      clear_queues();
      meas.meas_ready = 1'b0;
      repeat (5) pulse(2, 3);
      n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_at_full: got %b want 0", overflow); else n_pass++;
      n_checks++;
      if (meas.meas_valid !== 1'b1 || meas.meas_period !== 16'd5 || meas.meas_width !== 16'd2)
         $display("FAIL ovf_head: got v=%b {%0d,%0d} want v=1 {5,2}", meas.meas_valid, meas.meas_period, meas.meas_width);
      else n_pass++;
      pulse(2, 3);
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else n_pass++;
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
      pulse_x(2, 3, 1'b1, 1'b0);
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set_beats_clear: got %b want 1", overflow); else n_pass++;
      drain(4);
      n_checks++; if (got_p.size() != 4) $display("FAIL ovf_retained_count: got %0d want 4", got_p.size()); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= got_p.size() || got_p[i] !== 32'd5 || got_w[i] !== 32'd2)
            $display("FAIL ovf_rec%0d: got {%0d,%0d} want {5,2}", i,
                     (i < got_p.size()) ? got_p[i] : 0, (i < got_w.size()) ? got_w[i] : 0);
         else n_pass++;
      end
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
   endtask

   task automatic test_full_push_pop();
      int h[7];
      int l[7];
      rearm();
      clear_queues();
      meas.meas_ready = 1'b0;
      for (int k = 0; k < 7; k++) begin
         h[k] = $urandom_range(2, 5);
         l[k] = $urandom_range(2, 5);
         if (k < 5) begin
            exp_p.push_back(sat(h[k] + l[k]));
            exp_w.push_back(sat(h[k]));
         end
      end
      for (int k = 0; k < 5; k++) pulse(h[k], l[k]);
      // Sixth rise pushes into a full FIFO while the consumer takes the head
      pulse_x(h[5], l[5], 1'b0, 1'b1);
      n_checks++; if (overflow !== 1'b0) $display("FAIL full_pp_overflow: got %b want 0", overflow); else n_pass++;
      n_checks++; if (got_p.size() != 1) $display("FAIL full_pp_popped: got %0d want 1", got_p.size()); else n_pass++;
      drain(5);
      n_checks++; if (got_p.size() != 5) $display("FAIL full_pp_count: got %0d want 5", got_p.size()); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (i >= got_p.size() || got_p[i] !== exp_p[i] || got_w[i] !== exp_w[i])
            $display("FAIL full_pp_rec%0d: got {%0d,%0d} want {%0d,%0d}", i,
                     (i < got_p.size()) ? got_p[i] : 0, (i < got_w.size()) ? got_w[i] : 0, exp_p[i], exp_w[i]);
         else n_pass++;
      end
   endtask

   task automatic test_enable_and_reset();
      int h[6];
      int l[6];
      rearm();
      clear_queues();
      meas.meas_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         h[k] = $urandom_range(2, 6);
         l[k] = $urandom_range(2, 6);
      end
      pulse_in = 1'b1;
      repeat (3) tick();
      enable = 1'b0;
      repeat (2) tick();
      pulse_in = 1'b0;
      tick();
      enable = 1'b1;
      repeat (3) tick();
      for (int k = 0; k < 3; k++) pulse(h[k], l[k]);
      for (int k = 0; k < 2; k++) begin
         exp_p.push_back(sat(h[k] + l[k]));
         exp_w.push_back(sat(h[k]));
      end
      drain(2);
      n_checks++; if (got_p.size() != 2) $display("FAIL en_count: got %0d want 2", got_p.size()); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (i >= got_p.size() || got_p[i] !== exp_p[i] || got_w[i] !== exp_w[i])
            $display("FAIL en_rec%0d: got {%0d,%0d} want {%0d,%0d}", i,
                     (i < got_p.size()) ? got_p[i] : 0, (i < got_w.size()) ? got_w[i] : 0, exp_p[i], exp_w[i]);
         else n_pass++;
      end
      // Park one record, then hit reset while the FSM sits in LOW
      meas.meas_ready = 1'b0;
      pulse(4, 2);
      n_checks++; if (meas.meas_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", meas.meas_valid); else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++; if (meas.meas_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", meas.meas_valid); else n_pass++;
      n_checks++; if (meas.meas_period !== 16'd0) $display("FAIL midrst_period: got %0d want 0", meas.meas_period); else n_pass++;
      n_checks++; if (meas.meas_width !== 16'd0) $display("FAIL midrst_width: got %0d want 0", meas.meas_width); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL midrst_overflow: got %b want 0", overflow); else n_pass++;
      repeat (2) tick();
      reset = 1'b1;
      clear_queues();
      meas.meas_ready = 1'b1;
      repeat (3) tick();
      for (int k = 3; k < 6; k++) pulse(h[k], l[k]);
      for (int k = 3; k < 5; k++) begin
         exp_p.push_back(sat(h[k] + l[k]));
         exp_w.push_back(sat(h[k]));
      end
      drain(2);
      n_checks++; if (got_p.size() != 2) $display("FAIL postrst_count: got %0d want 2", got_p.size()); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (i >= got_p.size() || got_p[i] !== exp_p[i] || got_w[i] !== exp_w[i])
            $display("FAIL postrst_rec%0d: got {%0d,%0d} want {%0d,%0d}", i,
                     (i < got_p.size()) ? got_p[i] : 0, (i < got_w.size()) ? got_w[i] : 0, exp_p[i], exp_w[i]);
         else n_pass++;
      end
   endtask

`ifdef PSTAT_TIMEOUT_EN
   task automatic test_timeout();
      int r, hits, hit_cyc;
      rearm();
      clear_queues();
      meas.meas_ready = 1'b1;
      hits = 0;
      hit_cyc = -1;
      pulse_in = 1'b1;
      r = cyc + 1;
      for (int i = 0; i < 90; i++) begin
         if (i == 3) pulse_in = 1'b0;
         tick();
         if (timeout === 1'b1) begin
            hits++;
            hit_cyc = cyc;
         end
      end
      n_checks++; if (hits != 1) $display("FAIL tmo_pulses: got %0d want 1", hits); else n_pass++;
      n_checks++; if (hit_cyc != r + 50) $display("FAIL tmo_cycle: got %0d want %0d", hit_cyc, r + 50); else n_pass++;
      pulse(3, 4);
      pulse(3, 4);
      drain(1);
      n_checks++;
      if (got_p.size() != 1 || got_p[0] !== 32'd7 || got_w[0] !== 32'd3)
         $display("FAIL tmo_after_rec: got n=%0d {%0d,%0d} want n=1 {7,3}", got_p.size(),
                  (got_p.size() > 0) ? got_p[0] : 0, (got_w.size() > 0) ? got_w[0] : 0);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_random_stream();
      test_overflow();
      test_full_push_pop();
      test_enable_and_reset();
`ifdef PSTAT_TIMEOUT_EN
      test_timeout();
`else
      test_saturate();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
